rv32_id_stage: RTL and testbench



---
 rtl/rv32_id_stage_pkg.sv | 61 ++++++
 rtl/rv32_id_stage_if.sv | 39 +++
 rtl/rv32_id_stage_reg_file.sv | 34 +++
 rtl/rv32_id_stage.sv | 154 +++++++++++++++
 tb/tb_rv32_id_stage.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_id_stage_pkg.sv
// Shared constants, opcode map and ALU codes for the RV32I decode stage.
package rv32_id_stage_pkg;

  localparam int WORD_SIZE = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_SEL   = 5;
  localparam int ADDR_SIZE = 10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch;
    logic jump;
  } ctrl_t;

  // SUB only exists for register-register ops; the immediate form of funct3=000 is always ADDI.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt,
                                             input logic is_reg);
    case (funct3)
      3'd0:    return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_id_stage_if.sv
// IF/WB-facing inputs and ID/EX-facing outputs of the decode stage.
interface rv32_id_stage_if;
  import rv32_id_stage_pkg::*;

  logic [ADDR_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] instr;
  logic                 reg_write;
  logic [WORD_SIZE-1:0] rd_data;
  logic [REG_SEL-1:0]   rd_select;

  logic [ADDR_SIZE-1:0] pc_out;
  logic [WORD_SIZE-1:0] immd;
  logic [WORD_SIZE-1:0] data1;
  logic [WORD_SIZE-1:0] data2;
  logic [3:0]           alu_op;
  logic [REG_SEL-1:0]   rd;
  logic [REG_SEL-1:0]   rs1;
  logic [REG_SEL-1:0]   rs2;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_to_reg;
  logic                 reg_write_out;
  logic                 alu_src;
  logic                 branch;
  logic                 jump;

  modport master (
    output pc, instr, reg_write, rd_data, rd_select,
    input  pc_out, immd, data1, data2, alu_op, rd, rs1, rs2,
           mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump
  );

  modport slave (
    input  pc, instr, reg_write, rd_data, rd_select,
    output pc_out, immd, data1, data2, alu_op, rd, rs1, rs2,
           mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump
  );

endinterface

// File: rtl/rv32_id_stage_reg_file.sv
// 32x32 register file, two read ports and one write port, x0 hardwired to zero.
module rv32_id_stage_reg_file
  import rv32_id_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_SEL-1:0]   waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [REG_SEL-1:0]   raddr1,
  input  logic [REG_SEL-1:0]   raddr2,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic [WORD_SIZE-1:0] rdata2
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // A write landing on the same edge is forwarded so the ID/EX register captures the new value.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/rv32_id_stage.sv
// RV32I decode stage: field masking, immediate generation, control decode and ID/EX register.
module rv32_id_stage
  import rv32_id_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rv32_id_stage_if.slave id
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 funct7_b5;
  logic                 is_shift_imm;
  fmt_e                 fmt;
  ctrl_t                ctrl;
  alu_op_e              alu;
  logic [WORD_SIZE-1:0] imm;
  logic                 writes_rd;
  logic [REG_SEL-1:0]   rd_sel;
  logic [REG_SEL-1:0]   rs1_sel;
  logic [REG_SEL-1:0]   rs2_sel;
  logic [WORD_SIZE-1:0] rs1_val;
  logic [WORD_SIZE-1:0] rs2_val;

  assign opcode       = id.instr[6:0];
  assign funct3       = id.instr[14:12];
  assign funct7_b5    = id.instr[30];
  assign is_shift_imm = (opcode == OPC_OP_IMM) && (funct3[1:0] == 2'b01);

  always_comb begin
    fmt  = FMT_NONE;
    ctrl = '0;
    alu  = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        fmt = FMT_R;
        alu = alu_from_funct(funct3, funct7_b5, 1'b1);
      end
      OPC_OP_IMM: begin
        fmt          = FMT_I;
        ctrl.alu_src = 1'b1;
        alu          = alu_from_funct(funct3, funct7_b5, 1'b0);
      end
      OPC_LOAD: begin
        fmt             = FMT_I;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        fmt            = FMT_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        fmt          = FMT_B;
        ctrl.alu_src = 1'b1;
        ctrl.branch  = 1'b1;
        case (funct3[2:1])
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: alu = ALU_SUB;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        fmt          = (opcode == OPC_JAL) ? FMT_J : FMT_I;
        ctrl.alu_src = 1'b1;
        ctrl.jump    = 1'b1;
      end
      OPC_LUI: begin
        fmt          = FMT_U;
        ctrl.alu_src = 1'b1;
        alu          = ALU_PASS;
      end
      OPC_AUIPC: begin
        fmt          = FMT_U;
        ctrl.alu_src = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift immediates carry only the shamt, so funct7 (which marks SRAI) never leaks into immd.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = is_shift_imm ? {27'b0, id.instr[24:20]}
                                  : {{20{id.instr[31]}}, id.instr[31:20]};
      FMT_S:   imm = {{20{id.instr[31]}}, id.instr[31:25], id.instr[11:7]};
      FMT_B:   imm = {{19{id.instr[31]}}, id.instr[31], id.instr[7], id.instr[30:25],
                      id.instr[11:8], 1'b0};
      FMT_U:   imm = {id.instr[31:12], 12'b0};
      FMT_J:   imm = {{11{id.instr[31]}}, id.instr[31], id.instr[19:12], id.instr[20],
                      id.instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    writes_rd = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    rd_sel    = writes_rd                              ? id.instr[11:7]  : '0;
    rs1_sel   = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? id.instr[19:15] : '0;
    rs2_sel   = (fmt inside {FMT_R, FMT_S, FMT_B})        ? id.instr[24:20] : '0;
  end

  rv32_id_stage_reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (id.reg_write),
    .waddr  (id.rd_select),
    .wdata  (id.rd_data),
    .raddr1 (rs1_sel),
    .raddr2 (rs2_sel),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id.pc_out        <= '0;
      id.immd          <= '0;
      id.data1         <= '0;
      id.data2         <= '0;
      id.alu_op        <= '0;
      id.rd            <= '0;
      id.rs1           <= '0;
      id.rs2           <= '0;
      id.mem_read      <= 1'b0;
      id.mem_write     <= 1'b0;
      id.mem_to_reg    <= 1'b0;
      id.reg_write_out <= 1'b0;
      id.alu_src       <= 1'b0;
      id.branch        <= 1'b0;
      id.jump          <= 1'b0;
    end else begin
      id.pc_out        <= id.pc;
      id.immd          <= imm;
      id.data1         <= rs1_val;
      id.data2         <= rs2_val;
      id.alu_op        <= alu;
      id.rd            <= rd_sel;
      id.rs1           <= rs1_sel;
      id.rs2           <= rs2_sel;
      id.mem_read      <= ctrl.mem_read;
      id.mem_write     <= ctrl.mem_write;
      id.mem_to_reg    <= ctrl.mem_to_reg;
      id.reg_write_out <= writes_rd && (rd_sel != '0);
      id.alu_src       <= ctrl.alu_src;
      id.branch        <= ctrl.branch;
      id.jump          <= ctrl.jump;
    end
  end

endmodule

// File: tb/tb_rv32_id_stage.sv
// Self-checking bench for rv32_id_stage: directed decode vectors plus randomized instructions.
module tb_rv32_id_stage;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] model_regs [32];

  rv32_id_stage_if bus ();

  rv32_id_stage dut (
    .clk (clk),
    .rst (rst),
    .id  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [131:0] pack(input logic [9:0] p, input logic [31:0] im,
                                        input logic [31:0] d1, input logic [31:0] d2,
                                        input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [6:0] c);
    return {p, im, d1, d2, op, rd, rs1, rs2, c};
  endfunction

  function automatic logic [131:0] observed();
    return {bus.pc_out, bus.immd, bus.data1, bus.data2, bus.alu_op, bus.rd, bus.rs1, bus.rs2,
            bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write_out, bus.alu_src,
            bus.branch, bus.jump};
  endfunction

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic int reg_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? 1 : 0;
      3'd1:    return 2;
      3'd2:    return 3;
      3'd3:    return 4;
      3'd4:    return 5;
      3'd5:    return alt ? 7 : 6;
      3'd6:    return 8;
      default: return 9;
    endcase
  endfunction

  // Reference decode built from the format/field rules, using model_regs as architectural state.
  function automatic logic [131:0] model(input logic [9:0] p, input logic [31:0] w,
                                         input logic we, input logic [4:0] ws,
                                         input logic [31:0] wd);
    int         imm = 0;
    int         op = 0;
    bit         use_rd = 0, use_rs1 = 0, use_rs2 = 0;
    logic [5:0] c6 = 6'b0;
    logic [2:0] f3 = w[14:12];
    logic [4:0] rd, rs1, rs2;
    logic [31:0] d1, d2;
    int i_imm = sx(int'(w[31:20]), 12);
    case (w[6:0])
      7'h33: begin use_rd = 1; use_rs1 = 1; use_rs2 = 1; op = reg_op(f3, w[30]); end
      7'h13: begin
        use_rd = 1; use_rs1 = 1; c6 = 6'b000100;
        op  = (f3 == 3'd0) ? 0 : reg_op(f3, w[30]);
        imm = (f3 == 3'd1 || f3 == 3'd5) ? int'(w[24:20]) : i_imm;
      end
      7'h03: begin use_rd = 1; use_rs1 = 1; c6 = 6'b101100; imm = i_imm; end
      7'h23: begin
        use_rs1 = 1; use_rs2 = 1; c6 = 6'b010100;
        imm = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
      end
      7'h63: begin
        use_rs1 = 1; use_rs2 = 1; c6 = 6'b000110;
        op  = (f3 < 3'd4) ? 1 : ((f3 < 3'd6) ? 3 : 4);
        imm = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                 + int'(w[11:8]) * 2, 13);
      end
      7'h6f: begin
        use_rd = 1; c6 = 6'b000101;
        imm = sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12)
                 + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2, 21);
      end
      7'h67: begin use_rd = 1; use_rs1 = 1; c6 = 6'b000101; imm = i_imm; end
      7'h37: begin use_rd = 1; c6 = 6'b000100; op = 10; imm = int'(w & 32'hFFFFF000); end
      7'h17: begin use_rd = 1; c6 = 6'b000100; imm = int'(w & 32'hFFFFF000); end
      default: ;
    endcase
    rd  = use_rd  ? w[11:7]  : 5'd0;
    rs1 = use_rs1 ? w[19:15] : 5'd0;
    rs2 = use_rs2 ? w[24:20] : 5'd0;
    d1  = (rs1 == 0) ? 32'd0 : ((we && ws == rs1) ? wd : model_regs[rs1]);
    d2  = (rs2 == 0) ? 32'd0 : ((we && ws == rs2) ? wd : model_regs[rs2]);
    return pack(p, 32'(imm), d1, d2, 4'(op), rd, rs1, rs2,
                {c6[5], c6[4], c6[3], (use_rd && rd != 0), c6[2], c6[1], c6[0]});
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom();
    logic [6:0]  bad [4] = '{7'h0f, 7'h73, 7'h7f, 7'h00};
    int          coin = $urandom_range(0, 1);
    int          f3v  = $urandom_range(0, 5);
    case ($urandom_range(0, 9))
      0: begin
        w[6:0]   = 7'h33;
        w[31:25] = ((w[14:12] == 3'd0 || w[14:12] == 3'd5) && coin == 1) ? 7'h20 : 7'h00;
      end
      1: begin
        w[6:0] = 7'h13;
        if (w[14:12] == 3'd1) w[31:25] = 7'h00;
        else if (w[14:12] == 3'd5) w[31:25] = (coin == 1) ? 7'h20 : 7'h00;
      end
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: begin
        w[6:0]   = 7'h63;
        w[14:12] = 3'((f3v >= 2) ? f3v + 2 : f3v);
      end
      5: w[6:0] = 7'h6f;
      6: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      default: w[6:0] = bad[$urandom_range(0, 3)];
    endcase
    return w;
  endfunction

  task automatic step(input logic [9:0] p, input logic [31:0] w, input logic we,
                      input logic [4:0] ws, input logic [31:0] wd, output logic [131:0] exp);
    @(negedge clk);
    bus.pc        = p;
    bus.instr     = w;
    bus.reg_write = we;
    bus.rd_select = ws;
    bus.rd_data   = wd;
    exp = model(p, w, we, ws, wd);
    if (we && ws != 0) model_regs[ws] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [131:0] exp;
    logic [131:0] got;
    rst = 1'b0;
    bus.pc = 10'h3FF; bus.instr = 32'h04321ab7;
    bus.reg_write = 1'b1; bus.rd_select = 5'd5; bus.rd_data = 32'hAAAA5555;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    #12;
    got = observed();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("[TB] FAIL reset_hold got=%h exp=0", got);
    end
    @(posedge clk); #1;
    got = observed();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("[TB] FAIL reset_edge got=%h exp=0", got);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.reg_write = 1'b0;
    step(10'h010, 32'h005280B3, 1'b0, 5'd0, 32'd0, exp);
    got = observed();
    tests++;
    if (got !== pack(10'h010, 0, 0, 0, 0, 5'd1, 5'd5, 5'd5, 7'b0001000)) begin
      fails++;
      $display("[TB] FAIL reset_regs_cleared got=%h", got);
    end
  endtask

  task automatic test_preload();
    logic [131:0] exp;
    logic [131:0] got;
    for (int k = 1; k < 32; k++) begin
      step(10'(k), 32'h0, 1'b1, 5'(k), 32'(k), exp);
      got = observed();
      tests++;
      if (got !== pack(10'(k), 0, 0, 0, 0, 0, 0, 0, 7'b0)) begin
        fails++;
        $display("[TB] FAIL bubble[%0d] got=%h", k, got);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0]  ins  [7];
    logic [131:0] want [7];
    logic [131:0] exp;
    logic [131:0] got;
    ins[0] = 32'h00ee8c33; want[0] = pack(10'h040, 0, 29, 14, 0, 24, 29, 14, 7'b0001000);
    ins[1] = 32'h400bd633; want[1] = pack(10'h044, 0, 23, 0, 7, 12, 23, 0, 7'b0001000);
    ins[2] = 32'h00eb9013; want[2] = pack(10'h048, 14, 23, 0, 2, 0, 23, 0, 7'b0000100);
    ins[3] = 32'hed071e23; want[3] = pack(10'h04c, 32'hFFFFFEDC, 14, 16, 0, 0, 14, 16, 7'b0100100);
    ins[4] = 32'h12fc5863; want[4] = pack(10'h050, 304, 24, 15, 3, 0, 24, 15, 7'b0000110);
    ins[5] = 32'h701010ef; want[5] = pack(10'h054, 7936, 0, 0, 0, 1, 0, 0, 7'b0001101);
    ins[6] = 32'h04321ab7; want[6] = pack(10'h058, 32'h04321000, 0, 0, 10, 21, 0, 0, 7'b0001100);
    for (int i = 0; i < 7; i++) begin
      step(10'h040 + 10'(4 * i), ins[i], 1'b0, 5'd0, 32'd0, exp);
      got = observed();
      tests++;
      if (got !== want[i]) begin
        fails++;
        $display("[TB] FAIL directed[%0d] instr=%08h got=%h exp=%h", i, ins[i], got, want[i]);
      end
    end
  endtask

  task automatic test_write_through();
    logic [131:0] exp;
    logic [131:0] got;
    step(10'h060, 32'h005280B3, 1'b1, 5'd5, 32'hDEADBEEF, exp);
    got = observed();
    tests++;
    if (got !== pack(10'h060, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 5, 5, 7'b0001000)) begin
      fails++;
      $display("[TB] FAIL write_through got=%h", got);
    end
    step(10'h064, 32'h005280B3, 1'b0, 5'd0, 32'd0, exp);
    got = observed();
    tests++;
    if (got !== pack(10'h064, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 5, 5, 7'b0001000)) begin
      fails++;
      $display("[TB] FAIL write_persist got=%h", got);
    end
    step(10'h068, 32'h000000B3, 1'b1, 5'd0, 32'hFFFFFFFF, exp);
    got = observed();
    tests++;
    if (got !== pack(10'h068, 0, 0, 0, 0, 1, 0, 0, 7'b0001000)) begin
      fails++;
      $display("[TB] FAIL x0_write got=%h", got);
    end
  endtask

  task automatic test_random();
    logic [131:0] exp;
    logic [131:0] got;
    logic [31:0]  w;
    for (int i = 0; i < 400; i++) begin
      w = gen_instr();
      step(10'($urandom()), w, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom(), exp);
      got = observed();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL random[%0d] instr=%08h got=%h exp=%h", i, w, got, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [131:0] exp;
    logic [131:0] got;
    step(10'h070, 32'h04321ab7, 1'b0, 5'd0, 32'd0, exp);
    #2;
    rst = 1'b0;
    #1;
    got = observed();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("[TB] FAIL mid_reset_async got=%h exp=0", got);
    end
    @(posedge clk); #1;
    got = observed();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("[TB] FAIL mid_reset_hold got=%h exp=0", got);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    step(10'h074, 32'h005280B3, 1'b0, 5'd0, 32'd0, exp);
    got = observed();
    tests++;
    if (got !== pack(10'h074, 0, 0, 0, 0, 1, 5, 5, 7'b0001000)) begin
      fails++;
      $display("[TB] FAIL mid_reset_regs got=%h", got);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_directed();
    test_write_through();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
